// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - round-robin arbiter for regfile write ports, with conflict deferral and a pending bitmap
module wb_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int WRITE_PORTS = 2,
  parameter int AW          = 5,
  parameter int DW          = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ*AW-1:0]          req_addr_i,
  input  logic [NREQ*DW-1:0]          req_data_i,
  output logic [NREQ-1:0]             req_ready_o,
  output logic [WRITE_PORTS*AW-1:0]   wa_o,
  output logic [WRITE_PORTS-1:0]      wvalid_o,
  output logic [WRITE_PORTS*DW-1:0]   wd_o,
  output logic [31:0]                 pending_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]               ptr_q, ptr_d;
  logic [WRITE_PORTS-1:0]      wvalid_q, wvalid_d;
  logic [WRITE_PORTS*AW-1:0]   wa_q, wa_d;
  logic [WRITE_PORTS*DW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0]             grant;

  // Walk requesters from ptr; slots already filled this cycle hold the new
  // addresses in wa_d, so conflict checks compare against those.
  always_comb begin : select_walk
    int  n_grant;
    int  last;
    int  idx;
    logic hit;
    grant    = '0;
    wvalid_d = '0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    ptr_d    = ptr_q;
    n_grant  = 0;
    last     = 0;
    idx      = 0;
    hit      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == idx && req_valid_i[i] && n_grant < WRITE_PORTS) begin
          hit = 1'b0;
          for (int j = 0; j < WRITE_PORTS; j++) begin
            if (j < n_grant && req_addr_i[i*AW +: AW] != '0 &&
                wa_d[j*AW +: AW] == req_addr_i[i*AW +: AW]) begin
              hit = 1'b1;
            end
          end
          if (!hit) begin
            grant[i] = 1'b1;
            for (int j = 0; j < WRITE_PORTS; j++) begin
              if (j == n_grant) begin
                wa_d[j*AW +: AW] = req_addr_i[i*AW +: AW];
                wd_d[j*DW +: DW] = req_data_i[i*DW +: DW];
                wvalid_d[j]      = (req_addr_i[i*AW +: AW] != '0);
              end
            end
            n_grant = n_grant + 1;
            last    = i;
          end
        end
      end
    end
    if (n_grant > 0) begin
      ptr_d = PW'((last + 1) % NREQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      wvalid_q <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wvalid_q <= wvalid_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign req_ready_o = rst_ni ? grant : '0;
  assign wa_o        = wa_q;
  assign wvalid_o    = wvalid_q;
  assign wd_o        = wd_q;

  always_comb begin : pending_decode
    pending_o = '0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      for (int r = 1; r < 32; r++) begin
        if (rst_ni && wvalid_q[j] && wa_q[j*AW +: AW] == AW'(r)) begin
          pending_o[r] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for wb_write_arbiter with directed and random traffic
module tb_wb_write_arbiter;

  localparam int NREQ = 4;
  localparam int WP   = 2;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [WP*AW-1:0]     wa;
  logic [WP-1:0]        wvalid;
  logic [WP*DW-1:0]     wd;
  logic [31:0]          pending;

  always #5 clk = ~clk;

  wb_write_arbiter #(.NREQ(NREQ), .WRITE_PORTS(WP), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .wa_o(wa), .wvalid_o(wvalid), .wd_o(wd),
    .pending_o(pending)
  );

  typedef struct {
    int              cyc;
    logic [WP-1:0]   v;
    logic [WP*AW-1:0] a;
    logic [WP*DW-1:0] d;
  } wr_t;

  wr_t             sb[$];
  int              n_chk = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              mptr = 0;
  bit              hv[NREQ];
  logic [AW-1:0]   ha[NREQ];
  logic [DW-1:0]   hd[NREQ];
  logic [NREQ-1:0] last_ready;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic hold(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    hv[i] = 1'b1;
    ha[i] = a;
    hd[i] = d;
  endtask

  // One cycle: drive held requests, predict grants from the rules, queue expected port writes.
  task automatic step();
    logic [NREQ-1:0] exp_r;
    logic [AW-1:0]   gaddr[$];
    int              used, last, idx;
    bit              clash;
    wr_t             e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = hv[i];
      req_addr[i*AW +: AW] = ha[i];
      req_data[i*DW +: DW] = hd[i];
    end
    #1;
    exp_r = '0; used = 0; last = -1;
    e.cyc = cyc + 1; e.v = '0; e.a = '0; e.d = '0;
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (hv[idx] && used < WP) begin
          clash = 1'b0;
          if (ha[idx] != 0)
            foreach (gaddr[g]) if (gaddr[g] == ha[idx]) clash = 1'b1;
          if (!clash) begin
            exp_r[idx] = 1'b1;
            gaddr.push_back(ha[idx]);
            e.v[used]           = (ha[idx] != 0);
            e.a[used*AW +: AW]  = ha[idx];
            e.d[used*DW +: DW]  = hd[idx];
            used++;
            last = idx;
          end
        end
      end
    end
    last_ready = req_ready;
    chk("req_ready", req_ready, exp_r);
    if (last >= 0) mptr = (last + 1) % NREQ;
    for (int i = 0; i < NREQ; i++) if (exp_r[i]) hv[i] = 1'b0;
    if (e.v != '0) sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin : monitor
    wr_t         e;
    logic [31:0] ep;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL write_missing: got nothing at cycle %0d expected wvalid %0h", e.cyc, e.v);
      end
      if (wvalid !== '0) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          chk("unexpected_write", wvalid, 0);
        end else begin
          e = sb.pop_front();
          chk("wvalid", wvalid, e.v);
          ep = '0;
          for (int j = 0; j < WP; j++) begin
            if (e.v[j]) begin
              chk("wa", wa[j*AW +: AW], e.a[j*AW +: AW]);
              chk("wd", wd[j*DW +: DW], e.d[j*DW +: DW]);
              ep[e.a[j*AW +: AW]] = 1'b1;
            end
          end
          chk("pending", pending, ep);
        end
      end else begin
        chk("pending_idle", pending, 0);
      end
    end
  end

  initial begin : stimulus
    logic [AW-1:0] a;
    int            r;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) hv[i] = 1'b0;
    for (int i = 0; i < NREQ; i++) hold(i, AW'(i + 1), 64'h1000 + 64'(i));

    step();
    #2;
    chk("reset_ready", last_ready, 0);
    chk("reset_wvalid", wvalid, 0);
    chk("reset_pending", pending, 0);
    rst_n = 1'b1;

    step();
    chk("rr0_ready", last_ready, 4'b0011);
    #2;
    chk("rr0_wa", wa, {5'd2, 5'd1});
    chk("rr0_wvalid", wvalid, 2'b11);
    step();
    chk("rr1_ready", last_ready, 4'b1100);
    #2;
    chk("rr1_wa", wa, {5'd4, 5'd3});

    hold(0, 5'd5, 64'hAA);
    hold(1, 5'd5, 64'hBB);
    step();
    chk("conf0_ready", last_ready, 4'b0001);
    #2;
    chk("conf0_wvalid", wvalid, 2'b01);
    chk("conf0_wa", wa[0 +: AW], 5'd5);
    chk("conf0_wd", wd[0 +: DW], 64'hAA);
    step();
    chk("conf1_ready", last_ready, 4'b0010);
    #2;
    chk("conf1_wd", wd[0 +: DW], 64'hBB);

    hold(2, 5'd0, 64'hFF);
    step();
    chk("a0_ready", last_ready, 4'b0100);
    #2;
    chk("a0_wvalid", wvalid, 2'b00);
    chk("a0_pending", pending, 0);

    hold(3, 5'd31, 64'h31);
    step();
    chk("p31_ready", last_ready, 4'b1000);
    #2;
    chk("p31_pending", pending, 32'h8000_0000);
    step();
    #2;
    chk("p31_cleared", pending, 0);

    hold(0, 5'd6, 64'h66);
    hold(1, 5'd7, 64'h77);
    step();
    chk("ar_ready", last_ready, 4'b0011);
    #2;
    chk("ar_wvalid_before", wvalid, 2'b11);
    #1;
    rst_n = 1'b0;
    mptr = 0;
    #1;
    chk("ar_wvalid_after", wvalid, 0);
    chk("ar_pending_after", pending, 0);
    chk("ar_ready_after", req_ready, 0);
    for (int i = 0; i < NREQ; i++) hold(i, AW'(8 + i), 64'h800 + 64'(i));
    step();
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_ptr_zero", last_ready, 4'b0011);

    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hv[i] && $urandom_range(99) < 60) begin
          r = $urandom_range(9);
          a = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : AW'(r - 1);
          hold(i, a, {$urandom, $urandom});
        end
      end
      step();
    end

    for (int i = 0; i < NREQ; i++) hv[i] = 1'b0;
    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the architectural register file's write ports among several writeback requesters, for example the ALU, load unit, multiplier/divider and CSR unit. Each cycle it selects up to WRITE_PORTS requests in round-robin order and drops any same-destination conflict to the next cycle. The selected writes are registered onto the regfile write interface (`wa`/`wvalid`/`wd`), so they commit to the regfile one cycle later. The block sits between the writeback stage and the regfile; it also exports a pending-write bitmap that issue logic uses for hazard checks.

## Interface
- `NREQ`, default 4: number of writeback requesters.
- `WRITE_PORTS`, default `AREG_WRITE_PORTS`: regfile write ports driven.
- `AW`, default 5: register address width.
- `DW`, default 64: data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req_valid`  in  NREQ  requester i holds a write.
- `req_addr`  in  NREQ×AW  destination register per requester.
- `req_data`  in  NREQ×DW  write data per requester.
- `req_ready`  out  NREQ  request i accepted this cycle.
- `wa`  out  WRITE_PORTS×AW  regfile write address, registered.
- `wvalid`  out  WRITE_PORTS  regfile write enable, registered.
- `wd`  out  WRITE_PORTS×DW  regfile write data, registered.
- `pending`  out  32  bit r is set when a registered write to r is on the ports this cycle.

## Operation
- **Handshake:** a request transfers in a cycle where `req_valid[i]` and `req_ready[i]` are both 1.
  - `req_ready` is combinational from `req_valid`, `req_addr` and the round-robin pointer.
  - Requesters hold valid, addr and data stable until accepted.
- **Pointer:** `ptr`, range 0..NREQ-1.
- **Scan order:** ptr, ptr+1, …, ptr+NREQ-1, all mod NREQ.
- **Selection walk:** a requester is granted if all of the following hold:
  - it is valid;
  - fewer than WRITE_PORTS grants have been made so far this cycle;
  - its address (when nonzero) does not equal the address of an earlier grant in the same scan.
- **Conflicts:** a losing requester sees `req_ready`=0 and retries next cycle.
- **Slot assignment:** the k-th grant in scan order goes to port slot k. Unused slots have `wvalid`=0, and their `wa`/`wd` hold their previous values.
- **Address 0:**
  - The request is granted and acknowledged normally, and consumes a slot.
  - The slot's `wvalid` is registered as 0, so the write is dropped.
  - It never conflicts with another request.
- **Pointer update:**
  - If at least one grant was made, `ptr` ← (index of the last granted requester + 1) mod NREQ.
  - If no grant was made, `ptr` is unchanged.
- **Pending bitmap:** `pending` is decoded combinationally from the registered `wa`/`wvalid`. Bit 0 is always 0.
- **Masking:** no requester is ever granted twice in one cycle. When NREQ ≤ WRITE_PORTS, every valid non-conflicting request is granted.

## Timing
- **Reset (asynchronous, while `reset`=0):**
  - `wvalid`=0, `wa`=0, `wd`=0, `ptr`=0;
  - `req_ready`=0 and `pending`=0, forced regardless of the inputs.
- **Reset mid-operation:**
  - Writes already registered on the ports are cancelled immediately (`wvalid` drops asynchronously).
  - Requests are not acknowledged during reset.
- **Reset release:** selection begins on the first rising edge with `reset`=1.
- **Latency:** a request accepted in cycle N appears on the ports with `wvalid`=1 in cycle N+1, and the regfile content updates at the end of N+1.
- **Throughput:** up to WRITE_PORTS accepted writes per cycle. There are no bubbles between back-to-back grants.
- **Simultaneous events:** a same-address pair that is split across cycles writes the older-priority value first. A later registered write to the same register overwrites the earlier one in the regfile.
- **Ports:** all port outputs are registered; there is no combinational path from `req_*` to `wa`/`wvalid`/`wd`.

## Test plan
- **Reset:** hold `reset`=0 with all `req_valid`=1.
  - Required: `req_ready`=0, `wvalid`=0, `pending`=0.
  - Release reset: in the first active cycle requesters 0 and 1 are granted.
- **Round-robin (NREQ=4, WRITE_PORTS=2):** all four valid with distinct addresses 1, 2, 3, 4.
  - Cycle 0 grants requesters 0 and 1; cycle 1 grants 2 and 3.
  - The ports show (1, 2) then (3, 4), each one cycle after acceptance.
- **Conflict:** ptr=0, requesters 0 and 1 both target x5 with data 0xAA and 0xBB.
  - Cycle 0: requester 0 granted; requester 1 `req_ready`=0.
  - Cycle 1 ports: x5 ← 0xAA. Cycle 2 ports: x5 ← 0xBB.
- **Address 0:** requester 2 valid with addr 0 and data 0xFF.
  - Required: acknowledged, the slot's `wvalid`=0, `pending`[0]=0.
- **Pending bitmap:** requester 3 writes x31.
  - Required: `pending`=0x8000_0000 exactly one cycle after acceptance, 0 the cycle after.
- **Asynchronous reset mid-write:** assert `reset`=0 between clock edges while `wvalid`=2'b11.
  - Required: `wvalid` goes to 0 before the next edge, and `ptr` returns to 0.
